skinny_sbox8_cms_pipelined: RTL and testbench

//  N-share CMS-masked SKINNY-128 8-bit S-box with a pipeline register after every nonlinear layer.

---
 rtl/skinny_cms_pkg.sv | 21 ++
 rtl/cms_sbox8_cfn_pipe.sv | 58 +++++
 rtl/skinny_sbox8_cms_pipelined.sv | 122 ++++++++++++
 tb/tb_skinny_sbox8_cms_pipelined.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/skinny_cms_pkg.sv
// Shared constants for the CMS-masked SKINNY-128 8-bit S-box pipeline.
// Gadget indices select each gadget's slice of the randomness bus.
package skinny_cms_pkg;

  localparam int SBOX8_LAT     = 4;
  localparam int SBOX8_NGADGET = 8;

  localparam int G_B764 = 0;
  localparam int G_B320 = 1;
  localparam int G_B216 = 2;
  localparam int G_B015 = 3;
  localparam int G_B131 = 4;
  localparam int G_B237 = 5;
  localparam int G_B303 = 6;
  localparam int G_B452 = 7;

  function automatic int rand_w(input int n);
    return SBOX8_NGADGET * n * n;
  endfunction

endpackage

// File: rtl/cms_sbox8_cfn_pipe.sv
// One CMS gadget computing NOR(a,b)^z on N-share bits.
// The cross products are refreshed, registered, then compressed after the register.
module cms_sbox8_cfn_pipe
  import skinny_cms_pkg::*;
#(
  parameter int N = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic [N-1:0]   z,
  input  logic [N*N-1:0] rr,
  output logic [N-1:0]   f
);

  localparam int NN = N * N;

  logic [N-1:0]  x, y, z_q;
  logic [NN-1:0] rg_d, rg_q;

  // Inverting share 0 alone inverts the unmasked value, so XOR of all x_i&y_j is ~a&~b.
  always_comb begin
    x    = a;
    y    = b;
    x[0] = ~a[0];
    y[0] = ~b[0];
    rg_d = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int k;
        k       = i * N + j;
        rg_d[k] = (x[i] & y[j]) ^ rr[k] ^ rr[(k + 1) % NN];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rg_q <= '0;
      z_q  <= '0;
    end else if (en) begin
      rg_q <= rg_d;
      z_q  <= z;
    end
  end

  always_comb begin
    f = z_q;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        f[i] = f[i] ^ rg_q[i * N + j];
      end
    end
  end

endmodule

// File: rtl/skinny_sbox8_cms_pipelined.sv
// N-share CMS-masked SKINNY-128 S8 with a register after each of its four nonlinear layers.
// Input bits and early gadget results are delay-lined so every gadget sees one byte.
module skinny_sbox8_cms_pipelined
  import skinny_cms_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [8*N-1:0]         si,
  input  logic [rand_w(N)-1:0]   r,
  output logic                   out_valid,
  output logic [8*N-1:0]         so
);

  localparam int NN = N * N;

  logic [N-1:0] a [8];
  logic [N-1:0] b1d, b5d;
  logic [N-1:0] b3d [2];
  logic [N-1:0] b7d [2];
  logic [N-1:0] b2d [3];
  logic [N-1:0] a0d [3];
  logic [N-1:0] a1d [3];
  logic [N-1:0] a2d [3];
  logic [N-1:0] a3d [2];
  logic [N-1:0] a4d [2];
  logic [N-1:0] a5d, a6d;
  logic [SBOX8_LAT-1:0] vpipe;

  function automatic logic [N-1:0] bs(input logic [8*N-1:0] v, input int k);
    logic [N-1:0] t;
    t = '0;
    for (int s = 0; s < N; s++) t[s] = v[8 * s + k];
    return t;
  endfunction

  cms_sbox8_cfn_pipe #(.N(N)) u_g0 (.clk(clk), .rst_n(rst_n), .en(en),
    .a(bs(si, 7)), .b(bs(si, 6)), .z(bs(si, 4)), .rr(r[G_B764*NN +: NN]), .f(a[0]));
  cms_sbox8_cfn_pipe #(.N(N)) u_g1 (.clk(clk), .rst_n(rst_n), .en(en),
    .a(bs(si, 3)), .b(bs(si, 2)), .z(bs(si, 0)), .rr(r[G_B320*NN +: NN]), .f(a[1]));
  cms_sbox8_cfn_pipe #(.N(N)) u_g2 (.clk(clk), .rst_n(rst_n), .en(en),
    .a(bs(si, 2)), .b(bs(si, 1)), .z(bs(si, 6)), .rr(r[G_B216*NN +: NN]), .f(a[2]));
  cms_sbox8_cfn_pipe #(.N(N)) u_g3 (.clk(clk), .rst_n(rst_n), .en(en),
    .a(a[0]), .b(a[1]), .z(b5d), .rr(r[G_B015*NN +: NN]), .f(a[3]));
  cms_sbox8_cfn_pipe #(.N(N)) u_g4 (.clk(clk), .rst_n(rst_n), .en(en),
    .a(a[1]), .b(b3d[0]), .z(b1d), .rr(r[G_B131*NN +: NN]), .f(a[4]));
  cms_sbox8_cfn_pipe #(.N(N)) u_g5 (.clk(clk), .rst_n(rst_n), .en(en),
    .a(a2d[0]), .b(a[3]), .z(b7d[1]), .rr(r[G_B237*NN +: NN]), .f(a[5]));
  cms_sbox8_cfn_pipe #(.N(N)) u_g6 (.clk(clk), .rst_n(rst_n), .en(en),
    .a(a[3]), .b(a0d[0]), .z(b3d[1]), .rr(r[G_B303*NN +: NN]), .f(a[6]));
  cms_sbox8_cfn_pipe #(.N(N)) u_g7 (.clk(clk), .rst_n(rst_n), .en(en),
    .a(a4d[0]), .b(a[5]), .z(b2d[2]), .rr(r[G_B452*NN +: NN]), .f(a[7]));

  // Index 0 of each line lags its source by one enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b1d   <= '0;
      b5d   <= '0;
      a5d   <= '0;
      a6d   <= '0;
      vpipe <= '0;
      for (int i = 0; i < 2; i++) begin
        b3d[i] <= '0;
        b7d[i] <= '0;
        a3d[i] <= '0;
        a4d[i] <= '0;
      end
      for (int i = 0; i < 3; i++) begin
        b2d[i] <= '0;
        a0d[i] <= '0;
        a1d[i] <= '0;
        a2d[i] <= '0;
      end
    end else if (en) begin
      b1d    <= bs(si, 1);
      b5d    <= bs(si, 5);
      b3d[0] <= bs(si, 3);
      b3d[1] <= b3d[0];
      b7d[0] <= bs(si, 7);
      b7d[1] <= b7d[0];
      b2d[0] <= bs(si, 2);
      b2d[1] <= b2d[0];
      b2d[2] <= b2d[1];
      a0d[0] <= a[0];
      a0d[1] <= a0d[0];
      a0d[2] <= a0d[1];
      a1d[0] <= a[1];
      a1d[1] <= a1d[0];
      a1d[2] <= a1d[1];
      a2d[0] <= a[2];
      a2d[1] <= a2d[0];
      a2d[2] <= a2d[1];
      a3d[0] <= a[3];
      a3d[1] <= a3d[0];
      a4d[0] <= a[4];
      a4d[1] <= a4d[0];
      a5d    <= a[5];
      a6d    <= a[6];
      vpipe  <= {vpipe[SBOX8_LAT-2:0], in_valid};
    end
  end

  always_comb begin
    so = '0;
    for (int s = 0; s < N; s++) begin
      so[8 * s + 0] = a[7][s];
      so[8 * s + 1] = a5d[s];
      so[8 * s + 2] = a2d[2][s];
      so[8 * s + 3] = a4d[1][s];
      so[8 * s + 4] = a6d[s];
      so[8 * s + 5] = a1d[2][s];
      so[8 * s + 6] = a0d[2][s];
      so[8 * s + 7] = a3d[1][s];
    end
  end

  assign out_valid = vpipe[SBOX8_LAT-1];

endmodule

// File: tb/tb_skinny_sbox8_cms_pipelined.sv
// Drives N=2,3,4 instances with one unmasked byte stream under fresh masks/randomness
// and checks unmasked outputs against an enabled-cycle history of issued bytes.
module tb_skinny_sbox8_cms_pipelined;

  logic clk = 1'b0;
  logic rst_n;
  logic en = 1'b0;
  logic in_valid = 1'b0;
  logic [15:0]  si2 = '0;
  logic [23:0]  si3 = '0;
  logic [31:0]  si4 = '0;
  logic [31:0]  r2 = '0;
  logic [71:0]  r3 = '0;
  logic [127:0] r4 = '0;
  logic [15:0]  so2;
  logic [23:0]  so3;
  logic [31:0]  so4;
  logic ov2, ov3, ov4;
  logic [7:0] curVal = '0;

  int passCnt = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  skinny_sbox8_cms_pipelined #(.N(2)) dut2 (.clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(in_valid), .si(si2), .r(r2), .out_valid(ov2), .so(so2));
  skinny_sbox8_cms_pipelined #(.N(3)) dut3 (.clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(in_valid), .si(si3), .r(r3), .out_valid(ov3), .so(so3));
  skinny_sbox8_cms_pipelined #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(in_valid), .si(si4), .r(r4), .out_valid(ov4), .so(so4));

  // Unmasked S8 evaluated straight from the NOR/XOR network and output bit map.
  function automatic logic [7:0] sboxRef(input logic [7:0] b);
    logic a0, a1, a2, a3, a4, a5, a6, a7;
    a0 = ~(b[7] | b[6]) ^ b[4];
    a1 = ~(b[3] | b[2]) ^ b[0];
    a2 = ~(b[2] | b[1]) ^ b[6];
    a3 = ~(a0 | a1) ^ b[5];
    a4 = ~(a1 | b[3]) ^ b[1];
    a5 = ~(a2 | a3) ^ b[7];
    a6 = ~(a3 | a0) ^ b[3];
    a7 = ~(a4 | a5) ^ b[2];
    return {a3, a0, a1, a6, a4, a2, a5, a7};
  endfunction

  function automatic logic [7:0] xorShares(input logic [31:0] v, input int n);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < n; i++) acc = acc ^ v[8 * i +: 8];
    return acc;
  endfunction

  function automatic logic [31:0] mkShares(input logic [7:0] v, input int n, input bit zr);
    logic [31:0] s;
    logic [7:0] acc, m;
    s   = '0;
    acc = v;
    for (int i = 1; i < n; i++) begin
      m = zr ? 8'h00 : 8'($urandom_range(0, 255));
      s[8 * i +: 8] = m;
      acc = acc ^ m;
    end
    s[7:0] = acc;
    return s;
  endfunction

  // Model: the last four enabled-cycle slots, newest at index 0.
  logic [3:0] hv;
  logic [7:0] hval [4];
  bit zeroSo;
  int stepCount = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hv <= '0;
      for (int i = 0; i < 4; i++) hval[i] <= '0;
      zeroSo <= 1'b1;
      stepCount <= stepCount + 1;
    end else if (en) begin
      hv <= {hv[2:0], in_valid};
      hval[0] <= curVal;
      for (int i = 1; i < 4; i++) hval[i] <= hval[i-1];
      zeroSo <= 1'b0;
      stepCount <= stepCount + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    totalCnt++;
    if (act === expv) passCnt++;
    else $display("[TB] FAIL %s actual=%h required=%h t=%0t", name, act, expv, $time);
  endtask

  logic [15:0] prev2;
  logic [23:0] prev3;
  logic [31:0] prev4;
  int lastStep = -1;
  bit pinned = 0;

  task automatic checkOutput();
    logic [7:0] ev;
    if (!pinned) begin
      pinned = 1;
      chk("pin_s00", 32'(sboxRef(8'h00)), 32'h65);
      chk("pin_s01", 32'(sboxRef(8'h01)), 32'h4C);
      chk("pin_s02", 32'(sboxRef(8'h02)), 32'h6A);
      chk("pin_sFF", 32'(sboxRef(8'hFF)), 32'hFF);
    end
    ev = sboxRef(hval[3]);
    chk("ov_n2", 32'(ov2), 32'(hv[3]));
    chk("ov_n3", 32'(ov3), 32'(hv[3]));
    chk("ov_n4", 32'(ov4), 32'(hv[3]));
    if (hv[3]) begin
      chk("so_n2", 32'(xorShares(32'(so2), 2)), 32'(ev));
      chk("so_n3", 32'(xorShares(32'(so3), 3)), 32'(ev));
      chk("so_n4", 32'(xorShares(so4, 4)), 32'(ev));
    end
    if (zeroSo) begin
      chk("sozero_n2", 32'(so2), 32'h0);
      chk("sozero_n3", 32'(so3), 32'h0);
      chk("sozero_n4", so4, 32'h0);
    end
    if (stepCount == lastStep) begin
      chk("hold_n2", 32'(so2), 32'(prev2));
      chk("hold_n3", 32'(so3), 32'(prev3));
      chk("hold_n4", so4, prev4);
    end
    prev2 = so2;
    prev3 = so3;
    prev4 = so4;
    lastStep = stepCount;
  endtask

  always @(negedge clk or negedge rst_n) begin
    #1;
    checkOutput();
  end

  task automatic applyStimulus(input logic e, input logic v, input logic [7:0] val, input bit zr);
    logic [31:0] sh;
    logic [127:0] rnd;
    en = e;
    in_valid = v;
    curVal = val;
    sh = mkShares(val, 2, zr);
    si2 = sh[15:0];
    sh = mkShares(val, 3, zr);
    si3 = sh[23:0];
    sh = mkShares(val, 4, zr);
    si4 = sh;
    rnd = zr ? 128'h0 : {$urandom, $urandom, $urandom, $urandom};
    r2 = rnd[31:0];
    r3 = rnd[71:0];
    r4 = rnd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(1, 1, 8'h00, 1);
    applyStimulus(1, 1, 8'h01, 0);
    applyStimulus(1, 1, 8'hFF, 0);
    applyStimulus(1, 1, 8'h02, 0);
    repeat (4) applyStimulus(1, 0, 8'($urandom), 0);

    for (int v = 0; v < 256; v++) applyStimulus(1, 1, 8'(v), 0);
    repeat (4) applyStimulus(1, 0, 8'($urandom), 0);

    $display("[TB] stall sequence");
    applyStimulus(1, 1, 8'hA5, 0);
    applyStimulus(1, 0, 8'h11, 0);
    applyStimulus(1, 1, 8'h3C, 0);
    repeat (3) applyStimulus(0, 1'($urandom), 8'($urandom), 0);
    repeat (6) applyStimulus(1, 0, 8'($urandom), 0);

    for (int i = 0; i < 300; i++)
      applyStimulus(($urandom % 4) != 0, 1'($urandom), 8'($urandom), 0);
    repeat (4) applyStimulus(1, 0, 8'($urandom), 0);

    $display("[TB] mid-flight reset");
    repeat (3) applyStimulus(1, 1, 8'($urandom), 0);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) applyStimulus(1, 0, 8'($urandom), 0);

    applyStimulus(1, 1, 8'h01, 0);
    repeat (5) applyStimulus(1, 0, 8'($urandom), 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
